cic_rx_frame_aligner: RTL and testbench

Receive-side stage directly downstream of the CIC front-end emulator's 32-bit e-port output sampled at 40 MHz. Hunts for the packet sync header at any of 8 nibble offsets, confirms periodic recurrence, then locks. While locked, emits nibble-aligned 32-bit words with SOP/EOP framing to the DTC packet processing logic. Each packet is 256 bits: 64 CLK320 nibbles, i.e. 8 words.

---
 rtl/cic_rx_frame_aligner_pkg.sv | 28 ++
 rtl/cic_rx_frame_aligner_if.sv | 33 +++
 rtl/cic_rx_frame_aligner_nibble_window_sel.sv | 16 +
 rtl/cic_rx_frame_aligner.sv | 207 ++++++++++++++++++++
 tb/tb_cic_rx_frame_aligner.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cic_rx_frame_aligner_pkg.sv
// Shared definitions for the CIC receive-side frame aligner and the
// transmit-side emulator: aligner state encoding, nibble geometry,
// default framing constants and the nibble window selection function.
package cic_rx_pkg;

  typedef enum logic [1:0] {
    HUNT,
    CONFIRM,
    LOCKED
  } state_t;

  localparam int unsigned NIBBLE_W          = 4;
  localparam int unsigned NUM_OFFSETS       = 8;

  localparam int unsigned DEF_SYNC_W        = 16;
  localparam logic [15:0] DEF_SYNC_WORD     = 16'hF0A5;
  localparam int unsigned DEF_WORDS_PER_PKT = 8;
  localparam int unsigned DEF_LOCK_COUNT    = 3;
  localparam int unsigned DEF_MISS_LIMIT    = 4;

  // 32-bit word starting k nibbles into the 64-bit window (earliest nibble at MSB).
  function automatic logic [31:0] nibble_sel(input logic [63:0] win, input logic [2:0] k);
    logic [63:0] shifted;
    shifted = win << (32'(k) * NIBBLE_W);
    return shifted[63:32];
  endfunction

endpackage

// File: rtl/cic_rx_frame_aligner_if.sv
// E-port input and aligned packet output bundle of the CIC frame aligner.
// master: the aligner; slave: the e-port source / packet consumer side.
// With ALIGN_STATS_EN defined the PKT_CNT/LOSS_CNT statistics are carried too.
interface cic_rx_frame_aligner_if;
  logic [31:0] EPORT_IN;
  logic [31:0] DATA_OUT;
  logic        DATA_VALID;
  logic        SOP;
  logic        EOP;
  logic        HDR_ERR;
  logic        LOCKED;
  logic [2:0]  OFFSET;
`ifdef ALIGN_STATS_EN
  logic [15:0] PKT_CNT;
  logic [15:0] LOSS_CNT;
`endif

  modport master (
    input  EPORT_IN,
    output DATA_OUT, DATA_VALID, SOP, EOP, HDR_ERR, LOCKED, OFFSET
`ifdef ALIGN_STATS_EN
    , output PKT_CNT, LOSS_CNT
`endif
  );

  modport slave (
    output EPORT_IN,
    input  DATA_OUT, DATA_VALID, SOP, EOP, HDR_ERR, LOCKED, OFFSET
`ifdef ALIGN_STATS_EN
    , input PKT_CNT, LOSS_CNT
`endif
  );
endinterface

// File: rtl/cic_rx_frame_aligner_nibble_window_sel.sv
// Combinational 64->32 selection of the word starting at a given nibble
// offset within the {previous, current} e-port window.
module nibble_window_sel
  import cic_rx_pkg::*;
(
  input  logic [63:0] win,
  input  logic [2:0]  offset,
  output logic [31:0] word
);

  // Pick the 32-bit word beginning 'offset' nibbles into the window.
  always_comb begin
    word = nibble_sel(win, offset);
  end

endmodule

// File: rtl/cic_rx_frame_aligner.sv
// CIC receive frame aligner: hunts for the sync header at any of 8 nibble
// offsets, confirms periodic recurrence, then emits nibble-aligned packet
// words with SOP/EOP/HDR_ERR framing while locked.
// Optional build macro ALIGN_STATS_EN adds PKT_CNT and LOSS_CNT counters.
module cic_rx_frame_aligner
  import cic_rx_pkg::*;
#(
  parameter int unsigned        SYNC_W        = DEF_SYNC_W,
  parameter logic [SYNC_W-1:0]  SYNC_WORD     = SYNC_W'(DEF_SYNC_WORD),
  parameter int unsigned        WORDS_PER_PKT = DEF_WORDS_PER_PKT,
  parameter int unsigned        LOCK_COUNT    = DEF_LOCK_COUNT,
  parameter int unsigned        MISS_LIMIT    = DEF_MISS_LIMIT
) (
  input  logic                   CLK40,
  input  logic                   RST_N,
  cic_rx_frame_aligner_if.master bus
);

  localparam int unsigned WCNT_W = (WORDS_PER_PKT > 1) ? $clog2(WORDS_PER_PKT) : 1;
  localparam int unsigned CONF_W = $clog2(LOCK_COUNT + 1);
  localparam int unsigned MISS_W = $clog2(MISS_LIMIT + 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WORDS_PER_PKT - 1);

  state_t            state;
  logic [31:0]       prev_q;
  logic [63:0]       win;
  logic [WCNT_W-1:0] wcnt;
  logic [WCNT_W-1:0] wcnt_next;
  logic [CONF_W-1:0] conf_cnt;
  logic [CONF_W-1:0] conf_inc;
  logic [MISS_W-1:0] miss_cnt;
  logic [MISS_W-1:0] miss_inc;
  logic [2:0]        offset_q;

  logic [NUM_OFFSETS-1:0] hit;
  logic [2:0]             first_hit;
  logic                   any_hit;
  logic [31:0]            cand;
  logic [31:0]            sel_word;
  logic                   hdr_slot;
  logic                   drop_evt;

  logic [31:0] data_q;
  logic        valid_q;
  logic        sop_q;
  logic        eop_q;
  logic        hdr_err_q;
  logic        locked_q;

  assign win       = {prev_q, bus.EPORT_IN};
  assign wcnt_next = (wcnt == WCNT_LAST) ? '0 : wcnt + WCNT_W'(1);
  assign conf_inc  = conf_cnt + CONF_W'(1);
  assign miss_inc  = miss_cnt + MISS_W'(1);
  assign hdr_slot  = (wcnt == '0);
  assign drop_evt  = (state == LOCKED) && hdr_slot && !hit[offset_q]
                     && (miss_inc == MISS_W'(MISS_LIMIT));

  nibble_window_sel u_out_sel (
    .win    (win),
    .offset (offset_q),
    .word   (sel_word)
  );

  // Header match at every nibble offset; lowest matching offset wins the hunt.
  always_comb begin
    hit       = '0;
    cand      = '0;
    first_hit = '0;
    for (int unsigned k = 0; k < NUM_OFFSETS; k++) begin
      cand   = nibble_sel(win, 3'(k));
      hit[k] = (cand[31 -: SYNC_W] == SYNC_WORD);
    end
    for (int unsigned k = NUM_OFFSETS; k > 0; k--) begin
      if (hit[k-1]) first_hit = 3'(k - 1);
    end
    any_hit = |hit;
  end

  // Aligner FSM with registered packet outputs.
  always_ff @(posedge CLK40 or negedge RST_N) begin
    if (!RST_N) begin
      prev_q    <= '0;
      state     <= HUNT;
      wcnt      <= '0;
      conf_cnt  <= '0;
      miss_cnt  <= '0;
      offset_q  <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      hdr_err_q <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      prev_q    <= bus.EPORT_IN;
      data_q    <= '0;
      valid_q   <= 1'b0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      hdr_err_q <= 1'b0;
      case (state)
        HUNT: begin
          locked_q <= 1'b0;
          if (any_hit) begin
            offset_q <= first_hit;
            wcnt     <= WCNT_W'(1);
            conf_cnt <= CONF_W'(1);
            miss_cnt <= '0;
            if (LOCK_COUNT == 1) begin
              // The hunting header already completes the lock, so it is
              // emitted directly using the freshly found offset.
              state    <= LOCKED;
              locked_q <= 1'b1;
              valid_q  <= 1'b1;
              sop_q    <= 1'b1;
              data_q   <= nibble_sel(win, first_hit);
            end else begin
              state <= CONFIRM;
            end
          end
        end

        CONFIRM: begin
          wcnt <= wcnt_next;
          if (hdr_slot) begin
            if (hit[offset_q]) begin
              conf_cnt <= conf_inc;
              if (conf_inc == CONF_W'(LOCK_COUNT)) begin
                state    <= LOCKED;
                locked_q <= 1'b1;
                valid_q  <= 1'b1;
                sop_q    <= 1'b1;
                data_q   <= sel_word;
                miss_cnt <= '0;
              end
            end else begin
              state    <= HUNT;
              wcnt     <= '0;
              conf_cnt <= '0;
            end
          end
        end

        LOCKED: begin
          wcnt <= wcnt_next;
          if (drop_evt) begin
            state    <= HUNT;
            locked_q <= 1'b0;
            wcnt     <= '0;
            conf_cnt <= '0;
            miss_cnt <= '0;
          end else begin
            locked_q <= 1'b1;
            valid_q  <= 1'b1;
            data_q   <= sel_word;
            sop_q    <= hdr_slot;
            eop_q    <= (wcnt == WCNT_LAST);
            if (hdr_slot) begin
              if (hit[offset_q]) begin
                miss_cnt <= '0;
              end else begin
                miss_cnt  <= miss_inc;
                hdr_err_q <= 1'b1;
              end
            end
          end
        end

        default: begin
          state    <= HUNT;
          locked_q <= 1'b0;
          wcnt     <= '0;
          conf_cnt <= '0;
          miss_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.DATA_OUT   = data_q;
  assign bus.DATA_VALID = valid_q;
  assign bus.SOP        = sop_q;
  assign bus.EOP        = eop_q;
  assign bus.HDR_ERR    = hdr_err_q;
  assign bus.LOCKED     = locked_q;
  assign bus.OFFSET     = offset_q;

`ifdef ALIGN_STATS_EN
  logic [15:0] pkt_cnt;
  logic [15:0] loss_cnt;

  // Saturating counts of emitted packets and of lock losses.
  always_ff @(posedge CLK40 or negedge RST_N) begin
    if (!RST_N) begin
      pkt_cnt  <= '0;
      loss_cnt <= '0;
    end else begin
      if (sop_q && (pkt_cnt != '1)) pkt_cnt <= pkt_cnt + 16'd1;
      if (drop_evt && (loss_cnt != '1)) loss_cnt <= loss_cnt + 16'd1;
    end
  end

  assign bus.PKT_CNT  = pkt_cnt;
  assign bus.LOSS_CNT = loss_cnt;
`endif

endmodule

// File: tb/tb_cic_rx_frame_aligner.sv
// Directed bench for cic_rx_frame_aligner: builds nibble streams of 8-word
// packets, queues the words expected on the aligned output with the cycle
// they are due, and checks every cycle against that queue.
module tb_cic_rx_frame_aligner;

  typedef struct {
    int unsigned due;
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic        err;
  } exp_t;

  localparam logic [15:0] SYNC = 16'hF0A5;
  localparam logic [15:0] BAD  = 16'h0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  cic_rx_frame_aligner_if bus ();

  cic_rx_frame_aligner #(
    .SYNC_W        (16),
    .SYNC_WORD     (16'hF0A5),
    .WORDS_PER_PKT (8),
    .LOCK_COUNT    (3),
    .MISS_LIMIT    (4)
  ) dut (
    .CLK40 (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          tests      = 0;
  int          failed     = 0;
  int unsigned cyc        = 0;
  int unsigned phase_base = 0;
  int unsigned nib_pos    = 0;
  logic [3:0]  nib_q[$];
  exp_t        exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Payload nibbles stay below 8 so the header pattern only occurs where placed.
  function automatic logic [3:0] rnd_nib();
    return 4'($urandom_range(0, 7));
  endfunction

  function automatic logic [31:0] rnd_word();
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 8; i++) w = {w[27:0], rnd_nib()};
    return w;
  endfunction

  task automatic start_phase();
    phase_base = cyc;
    nib_pos    = 0;
    nib_q.delete();
  endtask

  task automatic add_fill(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      nib_q.push_back(rnd_nib());
      nib_pos++;
    end
  endtask

  task automatic add_pkt(input logic [15:0] hdr, input int unsigned nwords,
                         input bit emit, input bit err);
    int unsigned start;
    logic [31:0] w;
    start = nib_pos;
    for (int unsigned j = 0; j < nwords; j++) begin
      w = rnd_word();
      if (j == 0) w[31:16] = hdr;
      for (int i = 7; i >= 0; i--) nib_q.push_back(w[4*i +: 4]);
      nib_pos += 8;
      if (emit) begin
        exp_q.push_back('{due: phase_base + start / 8 + j + 1, data: w,
                          sop: (j == 0), eop: (j == nwords - 1), err: (j == 0) && err});
      end
    end
  endtask

  task automatic step(input logic [31:0] word);
    int unsigned edge_idx;
    exp_t e;
    bus.EPORT_IN = word;
    @(posedge clk);
    edge_idx = cyc;
    cyc++;
    #1;
    if (exp_q.size() > 0 && exp_q[0].due == edge_idx) begin
      e = exp_q.pop_front();
      chk("valid", 32'(bus.DATA_VALID), 32'd1);
      chk("data", bus.DATA_OUT, e.data);
      chk("sop", 32'(bus.SOP), 32'(e.sop));
      chk("eop", 32'(bus.EOP), 32'(e.eop));
      chk("hdr_err", 32'(bus.HDR_ERR), 32'(e.err));
    end else begin
      chk("idle_valid", 32'(bus.DATA_VALID), 32'd0);
    end
  endtask

  task automatic run_cycles(input int unsigned n);
    logic [31:0] w;
    for (int unsigned c = 0; c < n; c++) begin
      w = '0;
      for (int i = 0; i < 8; i++) begin
        if (nib_q.size() > 0) w = {w[27:0], nib_q.pop_front()};
        else                  w = {w[27:0], rnd_nib()};
      end
      step(w);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_data"},    bus.DATA_OUT, 32'd0);
    chk({tag, "_valid"},   32'(bus.DATA_VALID), 32'd0);
    chk({tag, "_sop"},     32'(bus.SOP), 32'd0);
    chk({tag, "_eop"},     32'(bus.EOP), 32'd0);
    chk({tag, "_hdr_err"}, 32'(bus.HDR_ERR), 32'd0);
    chk({tag, "_locked"},  32'(bus.LOCKED), 32'd0);
    chk({tag, "_offset"},  32'(bus.OFFSET), 32'd0);
`ifdef ALIGN_STATS_EN
    chk({tag, "_pkt_cnt"},  32'(bus.PKT_CNT), 32'd0);
    chk({tag, "_loss_cnt"}, 32'(bus.LOSS_CNT), 32'd0);
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    nib_q.delete();
    step('0);
    step('0);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.EPORT_IN = '0;

    do_reset();
    check_zero("reset");

    // Offset 0: lock on 3rd header, single corrupt header, then 4 in a row, relock.
    start_phase();
    add_pkt(SYNC, 8, 0, 0);
    add_pkt(SYNC, 8, 0, 0);
    add_pkt(SYNC, 8, 1, 0);
    add_pkt(SYNC, 8, 1, 0);
    add_pkt(BAD,  8, 1, 1);
    add_pkt(SYNC, 8, 1, 0);
    add_pkt(BAD,  8, 1, 1);
    add_pkt(BAD,  8, 1, 1);
    add_pkt(BAD,  8, 1, 1);
    add_pkt(BAD,  8, 0, 0);
    add_pkt(SYNC, 8, 0, 0);
    add_pkt(SYNC, 8, 0, 0);
    add_pkt(SYNC, 8, 1, 0);
    add_pkt(SYNC, 8, 1, 0);
    run_cycles(17);
    chk("a_locked_before", 32'(bus.LOCKED), 32'd0);
    run_cycles(1);
    chk("a_locked_rise", 32'(bus.LOCKED), 32'd1);
    chk("a_offset", 32'(bus.OFFSET), 32'd0);
    run_cycles(55);
    chk("a_locked_hold", 32'(bus.LOCKED), 32'd1);
    run_cycles(1);
    chk("a_locked_drop", 32'(bus.LOCKED), 32'd0);
    run_cycles(39);
    chk("a_relocked", 32'(bus.LOCKED), 32'd1);
    chk("a_relock_offset", 32'(bus.OFFSET), 32'd0);
    chk("a_drain", 32'(exp_q.size()), 32'd0);

    // Stream delayed by 3 nibbles: same latency, offset 3.
    do_reset();
    start_phase();
    add_fill(3);
    add_pkt(SYNC, 8, 0, 0);
    add_pkt(SYNC, 8, 0, 0);
    add_pkt(SYNC, 8, 1, 0);
    add_pkt(SYNC, 8, 1, 0);
    run_cycles(17);
    chk("b_locked_before", 32'(bus.LOCKED), 32'd0);
    run_cycles(1);
    chk("b_locked_rise", 32'(bus.LOCKED), 32'd1);
    chk("b_offset", 32'(bus.OFFSET), 32'd3);
    run_cycles(15);
    chk("b_drain", 32'(exp_q.size()), 32'd0);

    // Lone header then headers 5 words later: confirm aborts, relocks on the new train.
    do_reset();
    start_phase();
    add_pkt(SYNC, 5, 0, 0);
    add_pkt(SYNC, 8, 0, 0);
    add_pkt(SYNC, 8, 0, 0);
    add_pkt(SYNC, 8, 0, 0);
    add_pkt(SYNC, 8, 1, 0);
    add_pkt(SYNC, 8, 1, 0);
    run_cycles(30);
    chk("e_locked_before", 32'(bus.LOCKED), 32'd0);
    run_cycles(1);
    chk("e_locked_rise", 32'(bus.LOCKED), 32'd1);
    run_cycles(15);
    chk("e_drain", 32'(exp_q.size()), 32'd0);

    // Reset mid-packet while locked.
    do_reset();
    start_phase();
    add_pkt(SYNC, 8, 0, 0);
    add_pkt(SYNC, 8, 0, 0);
    add_pkt(SYNC, 8, 1, 0);
    add_pkt(SYNC, 8, 1, 0);
    run_cycles(20);
    chk("f_locked", 32'(bus.LOCKED), 32'd1);
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    exp_q.delete();
    nib_q.delete();
    step(rnd_word());
    check_zero("midrst_edge");
    rst_n = 1'b1;
    step(rnd_word());
    step(rnd_word());
    chk("f_locked_after", 32'(bus.LOCKED), 32'd0);

    // From the post-reset HUNT state a clean stream locks after 3 headers.
    start_phase();
    add_pkt(SYNC, 8, 0, 0);
    add_pkt(SYNC, 8, 0, 0);
    add_pkt(SYNC, 8, 1, 0);
    run_cycles(17);
    chk("g_locked_before", 32'(bus.LOCKED), 32'd0);
    run_cycles(1);
    chk("g_locked_rise", 32'(bus.LOCKED), 32'd1);
    run_cycles(7);
    chk("g_drain", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
